trap_unit: RTL and testbench

TRAP_UNIT -- requirements
Module: trap_unit

---
 rtl/trap_unit.sv | 131 +++++++++++++
 tb/tb_trap_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// Machine-mode trap controller: exception entry, MRET exit, and the M-mode CSR file
// (mstatus, mtvec, mscratch, mepc, mcause, mtval) with fetch redirect strobes.
module trap_unit #(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_en,
  input  logic [3:0]  exc_code,
  input  logic [63:0] exc_val,
  input  logic        mret,
  input  logic [63:0] pc_addr,
  input  logic [11:0] r_csr_addr,
  input  logic        we_csr,
  input  logic [63:0] w_csr_data,
  output logic [63:0] csr_data,
  output logic        csr_illegal,
  output logic [1:0]  priv_lvl,
  output logic        trap_taken,
  output logic        trap_done,
  output logic        pc_redirect,
  output logic [63:0] pc_redirect_target
);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, EXIT = 2'd2} state_t;

  state_t      state;
  logic        mie, mpie;
  logic [1:0]  mpp;
  logic [63:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mstatus, trap_cause, trap_val;
  logic        m_mode, mapped, take_trap, take_exit, csr_wr;

  assign m_mode  = (priv_lvl == 2'b11);
  assign mstatus = {51'b0, mpp, 3'b0, mpie, 3'b0, mie, 3'b0};

  always_comb begin
    mapped   = 1'b1;
    csr_data = '0;
    case (r_csr_addr)
      A_MSTATUS:  csr_data = mstatus;
      A_MTVEC:    csr_data = mtvec;
      A_MSCRATCH: csr_data = mscratch;
      A_MEPC:     csr_data = mepc;
      A_MCAUSE:   csr_data = mcause;
      A_MTVAL:    csr_data = mtval;
      default:    mapped   = 1'b0;
    endcase
  end

  assign csr_illegal = (we_csr | mapped) & ~m_mode;

  // MRET outside M-mode becomes an illegal-instruction trap (cause 2, tval 0)
  assign take_trap  = exc_en | (mret & ~m_mode);
  assign take_exit  = mret & m_mode;
  assign csr_wr     = we_csr & ~mret & m_mode;
  assign trap_cause = exc_en ? {60'b0, exc_code} : 64'd2;
  assign trap_val   = exc_en ? exc_val : 64'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      priv_lvl           <= 2'b11;
      mie                <= 1'b0;
      mpie               <= 1'b0;
      mpp                <= 2'b00;
      mtvec              <= MTVEC_RESET;
      mscratch           <= '0;
      mepc               <= '0;
      mcause             <= '0;
      mtval              <= '0;
      trap_taken         <= 1'b0;
      trap_done          <= 1'b0;
      pc_redirect        <= 1'b0;
      pc_redirect_target <= '0;
    end else begin
      trap_taken         <= 1'b0;
      trap_done          <= 1'b0;
      pc_redirect        <= 1'b0;
      pc_redirect_target <= '0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state              <= ENTRY;
            mepc               <= pc_addr & ~64'h3;
            mcause             <= trap_cause;
            mtval              <= trap_val;
            mpp                <= priv_lvl;
            mpie               <= mie;
            mie                <= 1'b0;
            priv_lvl           <= 2'b11;
            trap_taken         <= 1'b1;
            pc_redirect        <= 1'b1;
            pc_redirect_target <= mtvec & ~64'h3;
          end else if (take_exit) begin
            state              <= EXIT;
            priv_lvl           <= mpp;
            mie                <= mpie;
            mpie               <= 1'b1;
            mpp                <= 2'b00;
            trap_done          <= 1'b1;
            pc_redirect        <= 1'b1;
            pc_redirect_target <= mepc;
          end else if (csr_wr) begin
            case (r_csr_addr)
              A_MSTATUS: begin
                mie  <= w_csr_data[3];
                mpie <= w_csr_data[7];
                // MPP=10 is a reserved mode; it collapses to U
                mpp  <= (w_csr_data[12:11] == 2'b10) ? 2'b00 : w_csr_data[12:11];
              end
              A_MTVEC:    mtvec    <= w_csr_data & ~64'h3;
              A_MSCRATCH: mscratch <= w_csr_data;
              A_MEPC:     mepc     <= w_csr_data & ~64'h3;
              A_MCAUSE:   mcause   <= w_csr_data;
              A_MTVAL:    mtval    <= w_csr_data;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trap_unit.sv
// Bench for trap_unit: directed literal checks then randomized traffic against a
// behavioural model of the trap/CSR rules, compared every cycle.
module tb_trap_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        exc_en, mret, we_csr;
  logic [3:0]  exc_code;
  logic [63:0] exc_val, pc_addr, w_csr_data;
  logic [11:0] r_csr_addr;
  logic [63:0] csr_data, pc_redirect_target;
  logic        csr_illegal, trap_taken, trap_done, pc_redirect;
  logic [1:0]  priv_lvl;

  int total = 0;
  int bad   = 0;

  // model state
  logic [1:0]  m_priv, m_mpp;
  logic        m_mie, m_mpie;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic        e_taken, e_done, e_redir;
  logic [63:0] e_target;

  trap_unit #(.MTVEC_RESET(64'h100)) dut (
    .clk(clk), .rst(rst), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val),
    .mret(mret), .pc_addr(pc_addr), .r_csr_addr(r_csr_addr), .we_csr(we_csr),
    .w_csr_data(w_csr_data), .csr_data(csr_data), .csr_illegal(csr_illegal),
    .priv_lvl(priv_lvl), .trap_taken(trap_taken), .trap_done(trap_done),
    .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic mmapped(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || (a >= 12'h340 && a <= 12'h343);
  endfunction

  function automatic logic [63:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return (64'(m_mpp) << 11) | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_priv = 2'b11; m_mpp = 2'b00; m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = 64'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    e_taken = 0; e_done = 0; e_redir = 0; e_target = 0;
  endtask

  task automatic model_trap(input logic [63:0] cause, input logic [63:0] tval);
    m_mepc   = pc_addr & ~64'h3;
    m_mcause = cause;
    m_mtval  = tval;
    m_mpp    = m_priv;
    m_mpie   = m_mie;
    m_mie    = 1'b0;
    m_priv   = 2'b11;
    e_taken  = 1; e_redir = 1; e_target = m_mtvec & ~64'h3;
  endtask

  // One clock edge worth of the trap/CSR rules, driven by the inputs held across it
  task automatic model_step();
    logic busy;
    logic [1:0] p;
    if (rst) begin model_reset(); return; end
    busy = e_taken | e_done;
    e_taken = 0; e_done = 0; e_redir = 0; e_target = 0;
    if (busy) return;
    if (exc_en) model_trap(64'(exc_code), exc_val);
    else if (mret && m_priv != 2'b11) model_trap(64'd2, 64'd0);
    else if (mret) begin
      e_done = 1; e_redir = 1; e_target = m_mepc;
      m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
    end else if (we_csr && m_priv == 2'b11) begin
      case (r_csr_addr)
        12'h300: begin
          m_mie = w_csr_data[3]; m_mpie = w_csr_data[7];
          p = w_csr_data[12:11];
          m_mpp = (p == 2'd2) ? 2'd0 : p;
        end
        12'h305: m_mtvec    = w_csr_data & ~64'h3;
        12'h340: m_mscratch = w_csr_data;
        12'h341: m_mepc     = w_csr_data & ~64'h3;
        12'h342: m_mcause   = w_csr_data;
        12'h343: m_mtval    = w_csr_data;
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    chk("csr_data", csr_data, mread(r_csr_addr));
    chk("csr_illegal", 64'(csr_illegal),
        64'((we_csr || mmapped(r_csr_addr)) && m_priv != 2'b11));
    chk("priv_lvl", 64'(priv_lvl), 64'(m_priv));
    chk("trap_taken", 64'(trap_taken), 64'(e_taken));
    chk("trap_done", 64'(trap_done), 64'(e_done));
    chk("pc_redirect", 64'(pc_redirect), 64'(e_redir));
    chk("redirect_target", pc_redirect_target, e_target);
  endtask

  // inputs set at edge+1; compare at edge+2; model advances with the edge
  task automatic step();
    #1 compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic e, input logic [3:0] code, input logic [63:0] val,
                        input logic m, input logic [63:0] pc, input logic [11:0] a,
                        input logic we, input logic [63:0] wd);
    exc_en = e; exc_code = code; exc_val = val; mret = m; pc_addr = pc;
    r_csr_addr = a; we_csr = we; w_csr_data = wd;
  endtask

  task automatic rd_lit(input string nm, input logic [11:0] a, input logic [63:0] exp);
    r_csr_addr = a; we_csr = 1'b0;
    #1 chk(nm, csr_data, exp);
  endtask

  initial begin
    logic [11:0] a;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 12'h305, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_priv", 64'(priv_lvl), 64'd3);
    chk("rst_taken", 64'(trap_taken), 64'd0);
    rd_lit("rst_mtvec", 12'h305, 64'h100);
    step();
    rst = 1'b0;

    // exception from M-mode
    set_in(1, 4'd11, 0, 0, 64'h1004, 12'h341, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 12'h341, 0, 0);
    chk("entry_taken", 64'(trap_taken), 64'd1);
    chk("entry_target", pc_redirect_target, 64'h100);
    chk("entry_priv", 64'(priv_lvl), 64'd3);
    rd_lit("entry_mepc", 12'h341, 64'h1004);
    rd_lit("entry_mcause", 12'h342, 64'd11);
    rd_lit("entry_mstatus", 12'h300, 64'h1800);
    step();

    // MPP=00, MPIE=1, then MRET from M-mode
    set_in(0, 0, 0, 0, 0, 12'h300, 1, 64'h80); step();
    set_in(0, 0, 0, 0, 0, 12'h343, 1, 64'hDEAD); step();
    set_in(0, 0, 0, 1, 0, 12'h300, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 12'h300, 0, 0);
    chk("exit_done", 64'(trap_done), 64'd1);
    chk("exit_target", pc_redirect_target, 64'h1004);
    step();
    chk("exit_priv", 64'(priv_lvl), 64'd0);
    rd_lit("exit_mstatus", 12'h300, 64'h88);

    // U-mode: CSR write is illegal, MRET traps with cause 2
    set_in(0, 0, 0, 0, 0, 12'h340, 1, 64'h77);
    #1 chk("umode_illegal", 64'(csr_illegal), 64'd1);
    step();
    set_in(0, 0, 0, 1, 64'h2468, 12'h342, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 12'h342, 0, 0);
    chk("umret_taken", 64'(trap_taken), 64'd1);
    rd_lit("umret_mcause", 12'h342, 64'd2);
    rd_lit("umret_mtval", 12'h343, 64'd0);
    rd_lit("umode_mscratch", 12'h340, 64'd0);
    step();

    // exc_en + mret + CSR write in one cycle
    set_in(1, 4'd5, 64'h9, 1, 64'h2000, 12'h340, 1, 64'h55); step();
    set_in(0, 0, 0, 0, 0, 12'h340, 0, 0);
    chk("prio_taken", 64'(trap_taken), 64'd1);
    rd_lit("prio_mscratch", 12'h340, 64'd0);
    rd_lit("prio_mcause", 12'h342, 64'd5);
    step();

    // write masking and unmapped addresses
    set_in(0, 0, 0, 0, 0, 12'h305, 1, 64'h8000_0003); step();
    set_in(0, 0, 0, 0, 0, 12'h300, 1, 64'h1000);
    rd_lit("mtvec_mask", 12'h305, 64'h8000_0000);
    we_csr = 1'b1; r_csr_addr = 12'h300;
    step();
    set_in(0, 0, 0, 0, 0, 12'h7C0, 1, 64'hFFFF);
    rd_lit("mpp10_to_00", 12'h300, 64'h0);
    we_csr = 1'b1;
    step();
    set_in(1, 4'd1, 0, 0, 64'h40, 12'h7C0, 0, 0);
    rd_lit("unmapped_rd", 12'h7C0, 64'h0);
    step();
    chk("new_mtvec_target", pc_redirect_target, 64'h8000_0000);
    set_in(0, 0, 0, 0, 0, 12'h300, 0, 0);
    step();

    // reset in the middle of ENTRY
    set_in(1, 4'd3, 64'h1234, 0, 64'h3000, 12'h341, 0, 0); step();
    rst = 1'b1;
    model_reset();
    set_in(0, 0, 0, 0, 0, 12'h341, 0, 0);
    #1;
    chk("midrst_taken", 64'(trap_taken), 64'd0);
    chk("midrst_target", pc_redirect_target, 64'd0);
    chk("midrst_priv", 64'(priv_lvl), 64'd3);
    rd_lit("midrst_mstatus", 12'h300, 64'd0);
    rd_lit("midrst_mtvec", 12'h305, 64'h100);
    rd_lit("midrst_mscratch", 12'h340, 64'd0);
    rd_lit("midrst_mepc", 12'h341, 64'd0);
    rd_lit("midrst_mcause", 12'h342, 64'd0);
    rd_lit("midrst_mtval", 12'h343, 64'd0);
    @(posedge clk);
    model_step();
    #1 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0: a = 12'h300; 1: a = 12'h305; 2: a = 12'h340; 3: a = 12'h341;
        4: a = 12'h342; 5: a = 12'h343; 6: a = 12'h7C0;
        default: a = 12'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, a, 0, 0);
        step();
        rst = 1'b0;
      end else begin
        set_in($urandom_range(0, 9) == 0, 4'($urandom), {$urandom, $urandom},
               $urandom_range(0, 6) == 0, {$urandom, $urandom}, a,
               $urandom_range(0, 2) == 0, {$urandom, $urandom});
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
